// File: rtl/mdr_mar_unit_if.sv
// Memory-side request/acknowledge bundle for mdr_mar_unit.
// master = register unit, slave = word-addressed RAM.
interface mdr_mar_unit_if #(
  parameter int ADDR_W = 9
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mdr_mar_unit.sv
// MAR/MDR register pair with single-word read/write sequencer.
// Optional ack watchdog: define MEM_TIMEOUT_EN.
module mdr_mar_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [31:0]  BusMuxOut,
  input  logic         MARin,
  input  logic         MDRin,
  input  logic         rd_start,
  input  logic         wr_start,
  output logic [31:0]  BusMuxInMDR,
  output logic [31:0]  address,
  output logic         busy,
  output logic         done,
  output logic         err,
  mdr_mar_unit_if.master mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [31:0]       mdr;
  logic              idle;
  logic              waiting;
  logic              start;
  logic              ack_hit;
  logic              expire;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mdr_mar_unit: TIMEOUT must be >= 1");
  end

  assign idle    = (state == IDLE);
  assign waiting = (state == RD) || (state == WR);
  assign start   = idle && (rd_start || wr_start);
  assign ack_hit = waiting && mem.mem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  // ack on the expiry edge wins, so expire is gated by !mem_ack
  assign expire = waiting && !mem.mem_ack
                  && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (waiting && !mem.mem_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_start) begin
          state_nxt = RD;
        end else if (wr_start) begin
          state_nxt = WR;
        end
      end
      RD, WR: begin
        if (mem.mem_ack || expire) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: ;
      RD: begin
        mem.mem_req = 1'b1;
        busy        = 1'b1;
      end
      WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        busy        = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // loads only in IDLE keep mem_addr/mem_wdata stable per request
  always_ff @(posedge clock) begin
    if (!clear) begin
      mar <= '0;
    end else if (idle && MARin) begin
      mar <= BusMuxOut[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      mdr <= '0;
    end else if (ack_hit && (state == RD)) begin
      mdr <= mem.mem_rdata;
    end else if (idle && MDRin) begin
      mdr <= BusMuxOut;
    end
  end

  assign address       = {{(32-ADDR_W){1'b0}}, mar};
  assign BusMuxInMDR   = mdr;
  assign mem.mem_addr  = mar;
  assign mem.mem_wdata = mdr;

endmodule

// File: tb/tb_mdr_mar_unit.sv
// Self-checking bench for mdr_mar_unit: vector table,
// directed watchdog sequence and randomized model check.
module tb_mdr_mar_unit;
  localparam int AW = 9;
  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] bus   = '0;
  logic        marin = 1'b0;
  logic        mdrin = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] mdr_o;
  logic [31:0] addr_o;
  logic        busy;
  logic        done;
  logic        err;

  mdr_mar_unit_if #(.ADDR_W(AW)) mem ();

  mdr_mar_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock      (clock),
    .clear      (clear),
    .BusMuxOut  (bus),
    .MARin      (marin),
    .MDRin      (mdrin),
    .rd_start   (rd),
    .wr_start   (wr),
    .BusMuxInMDR(mdr_o),
    .address    (addr_o),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem        (mem)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        clr, mi, di, rs, ws, ack;
    logic [31:0] bus, rdata;
    logic        req, we, bsy, dn;
    logic [31:0] addr, mdr;
  } vec_t;

  function automatic vec_t mk(
    input logic clr, mi, di, rs, ws, ack,
    input logic [31:0] b, rdat,
    input logic req, we, bsy, dn,
    input logic [31:0] a, m);
    vec_t v;
    v.clr = clr; v.mi = mi; v.di = di;
    v.rs = rs; v.ws = ws; v.ack = ack;
    v.bus = b; v.rdata = rdat;
    v.req = req; v.we = we; v.bsy = bsy; v.dn = dn;
    v.addr = a; v.mdr = m;
    return v;
  endfunction

  task automatic check_outs(input string p,
                            input logic req, we, bsy, dn, er,
                            input logic [31:0] a, m);
    chk({p, ".req"}, 32'(mem.mem_req), 32'(req));
    chk({p, ".we"}, 32'(mem.mem_we), 32'(we));
    chk({p, ".busy"}, 32'(busy), 32'(bsy));
    chk({p, ".done"}, 32'(done), 32'(dn));
    chk({p, ".err"}, 32'(err), 32'(er));
    chk({p, ".address"}, addr_o, a);
    chk({p, ".mem_addr"}, 32'(mem.mem_addr), a);
    chk({p, ".mdr"}, mdr_o, m);
    chk({p, ".wdata"}, mem.mem_wdata, m);
  endtask

  vec_t tbl[25];

  // reference model state (transaction level)
  logic [AW-1:0] m_mar;
  logic [31:0]   m_mdr;
  bit            m_active, m_wr, m_done, m_err;
  int            m_wait;

  task automatic model_step();
    if (!clear) begin
      m_mar = '0; m_mdr = '0; m_active = 0;
      m_wr = 0; m_done = 0; m_err = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (mem.mem_ack) begin
        if (!m_wr) m_mdr = mem.mem_rdata;
        m_active = 0;
        m_done = 1;
      end else begin
        m_wait++;
`ifdef MEM_TIMEOUT_EN
        if (m_wait == TO) begin
          m_active = 0;
          m_done = 1;
          m_err = 1;
        end
`endif
      end
    end else begin
      if (marin) m_mar = bus[AW-1:0];
      if (mdrin) m_mdr = bus;
      if (rd || wr) begin
        m_active = 1;
        m_wr = !rd;
        m_wait = 0;
        m_err = 0;
      end
    end
  endtask

  task automatic idle_inputs();
    marin = 0; mdrin = 0; rd = 0; wr = 0;
    mem.mem_ack = 0;
  endtask

  initial begin
    int cnt;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;

    tbl[0]  = mk(0,1,1,1,0,1,32'hFFFF_FFFF,32'hFFFF_FFFF,
                 0,0,0,0,32'h0,32'h0);
    tbl[1]  = mk(1,1,0,0,0,0,32'h0000_01A5,32'h0,
                 0,0,0,0,32'h1A5,32'h0);
    tbl[2]  = mk(1,0,1,0,0,0,32'h1234_5678,32'h0,
                 0,0,0,0,32'h1A5,32'h1234_5678);
    tbl[3]  = mk(1,1,0,0,0,0,32'h0000_00FF,32'h0,
                 0,0,0,0,32'hFF,32'h1234_5678);
    tbl[4]  = mk(1,0,0,0,1,0,32'h0,32'h0,
                 1,1,1,0,32'hFF,32'h1234_5678);
    tbl[5]  = mk(1,0,0,0,0,1,32'h0,32'h5555_5555,
                 0,0,1,1,32'hFF,32'h1234_5678);
    tbl[6]  = mk(1,0,0,0,0,0,32'h0,32'h0,
                 0,0,0,0,32'hFF,32'h1234_5678);
    tbl[7]  = mk(1,1,0,0,0,0,32'h0000_0010,32'h0,
                 0,0,0,0,32'h10,32'h1234_5678);
    tbl[8]  = mk(1,0,0,1,0,0,32'h0,32'h0,
                 1,0,1,0,32'h10,32'h1234_5678);
    tbl[9]  = mk(1,0,0,0,0,0,32'h0,32'h0,
                 1,0,1,0,32'h10,32'h1234_5678);
    tbl[10] = mk(1,0,0,0,0,0,32'h0,32'h0,
                 1,0,1,0,32'h10,32'h1234_5678);
    tbl[11] = mk(1,0,0,0,0,0,32'h0,32'h0,
                 1,0,1,0,32'h10,32'h1234_5678);
    tbl[12] = mk(1,0,0,0,0,1,32'h0,32'hDEAD_BEEF,
                 0,0,1,1,32'h10,32'hDEAD_BEEF);
    tbl[13] = mk(1,0,0,0,0,0,32'h0,32'h0,
                 0,0,0,0,32'h10,32'hDEAD_BEEF);
    tbl[14] = mk(1,0,0,1,0,0,32'h0,32'h0,
                 1,0,1,0,32'h10,32'hDEAD_BEEF);
    tbl[15] = mk(1,1,1,0,1,0,32'h0000_00AA,32'h0,
                 1,0,1,0,32'h10,32'hDEAD_BEEF);
    tbl[16] = mk(1,0,0,0,0,1,32'h0,32'hCAFE_F00D,
                 0,0,1,1,32'h10,32'hCAFE_F00D);
    tbl[17] = mk(1,0,0,0,1,0,32'h0,32'h0,
                 0,0,0,0,32'h10,32'hCAFE_F00D);
    tbl[18] = mk(1,0,0,0,0,0,32'h0,32'h0,
                 0,0,0,0,32'h10,32'hCAFE_F00D);
    tbl[19] = mk(1,0,0,1,1,0,32'h0,32'h0,
                 1,0,1,0,32'h10,32'hCAFE_F00D);
    tbl[20] = mk(1,0,0,0,0,1,32'h0,32'h1111_2222,
                 0,0,1,1,32'h10,32'h1111_2222);
    tbl[21] = mk(1,0,0,0,0,0,32'h0,32'h0,
                 0,0,0,0,32'h10,32'h1111_2222);
    tbl[22] = mk(1,0,0,1,0,0,32'h0,32'h0,
                 1,0,1,0,32'h10,32'h1111_2222);
    tbl[23] = mk(0,0,0,0,0,0,32'h0,32'h0,
                 0,0,0,0,32'h0,32'h0);
    tbl[24] = mk(1,0,0,0,0,0,32'h0,32'h0,
                 0,0,0,0,32'h0,32'h0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      clear = tbl[i].clr; marin = tbl[i].mi;
      mdrin = tbl[i].di; rd = tbl[i].rs; wr = tbl[i].ws;
      bus = tbl[i].bus;
      mem.mem_ack = tbl[i].ack;
      mem.mem_rdata = tbl[i].rdata;
      @(posedge clock);
      #1;
      check_outs($sformatf("row%0d", i), tbl[i].req,
                 tbl[i].we, tbl[i].bsy, tbl[i].dn, 1'b0,
                 tbl[i].addr, tbl[i].mdr);
    end

    // watchdog sequence: request that is never acknowledged
    @(negedge clock);
    idle_inputs();
    clear = 1; mdrin = 1; bus = 32'h5A5A_5A5A;
    @(negedge clock);
    mdrin = 0; rd = 1;
    @(posedge clock);
    #1;
    @(negedge clock);
    rd = 0;
    cnt = 0;
`ifdef MEM_TIMEOUT_EN
    while (mem.mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clock);
      #1;
    end
    chk("to.req_cycles", 32'(cnt), 32'(TO));
    chk("to.done", 32'(done), 32'd1);
    chk("to.err", 32'(err), 32'd1);
    chk("to.mdr", mdr_o, 32'h5A5A_5A5A);
    @(posedge clock);
    #1;
    chk("to.err_hold", 32'(err), 32'd1);
    @(negedge clock);
    rd = 1;
    @(posedge clock);
    #1;
    chk("to.err_clr", 32'(err), 32'd0);
    @(negedge clock);
    rd = 0; mem.mem_ack = 1; mem.mem_rdata = 32'h0BAD_F00D;
    @(posedge clock);
    #1;
    chk("to.done2", 32'(done), 32'd1);
    chk("to.err2", 32'(err), 32'd0);
    chk("to.mdr2", mdr_o, 32'h0BAD_F00D);
`else
    while (mem.mem_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge clock);
      #1;
    end
    chk("wait.req_cycles", 32'(cnt), 32'd20);
    chk("wait.err", 32'(err), 32'd0);
    chk("wait.done", 32'(done), 32'd0);
    @(negedge clock);
    clear = 0;
    @(posedge clock);
    #1;
    chk("wait.clr_busy", 32'(busy), 32'd0);
`endif

    // randomized run against the reference model
    @(negedge clock);
    idle_inputs();
    clear = 0;
    model_step();
    @(posedge clock);
    #1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      clear = ($urandom_range(0, 63) != 0);
      bus = $urandom;
      mem.mem_rdata = $urandom;
      if (c < 400) mem.mem_ack = ($urandom_range(0, 3) == 0);
      else mem.mem_ack = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        marin = 1'($urandom); mdrin = 1'($urandom);
        rd = 0; wr = 0;
      end else begin
        rd = 1'($urandom); wr = 1'($urandom);
        marin = 0; mdrin = 0;
      end
      model_step();
      @(posedge clock);
      #1;
      check_outs($sformatf("rand%0d", c), m_active,
                 m_active && m_wr, m_active || m_done,
                 m_done, m_err,
                 {{(32-AW){1'b0}}, m_mar}, m_mdr);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
